ds_nn_scaler: RTL and testbench

//  Streaming nearest-neighbour downscaler with per-channel pixel selection. Generalises the fixed 256x256->96x96 DS96 selector.

---
 rtl/ds_scaler_pkg.sv | 26 ++
 rtl/ds_step_acc.sv | 44 ++++
 rtl/ds_nn_scaler.sv | 177 +++++++++++++++++
 tb/tb_ds_nn_scaler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_scaler_pkg.sv
// Shared state encoding and sizing helpers for the nearest-neighbour downscaler.
// DS_CH_SLICE(k, w) selects channel k of a packed pixel whose channels are w bits wide.
`ifndef DS_SCALER_PKG_SV
`define DS_SCALER_PKG_SV

`define DS_CH_SLICE(k, w) [(k)*(w) +: (w)]

package ds_scaler_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Holds acc + DST, which is always below 2*SRC.
  function automatic int acc_width(input int src);
    return $clog2(2 * src);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/ds_step_acc.sv
// One axis of the DDA selector: sel marks the source positions that map to an output sample.
// DS_SCALER_CENTER_EN starts the phase at SRC/2 instead of 0.
module ds_step_acc
  import ds_scaler_pkg::*;
#(
  parameter int SRC = 256,
  parameter int DST = 96
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic step,
  output logic sel
);

  localparam int AW = acc_width(SRC);
  localparam logic [AW-1:0] SRC_V = AW'(SRC);
  localparam logic [AW-1:0] DST_V = AW'(DST);
`ifdef DS_SCALER_CENTER_EN
  localparam logic [AW-1:0] INIT_V = AW'(SRC / 2);
`else
  localparam logic [AW-1:0] INIT_V = '0;
`endif

  logic [AW-1:0] acc_reg;
  logic [AW-1:0] base;
  logic [AW-1:0] sum;

  // init restarts the phase for the current position, so sel is valid on that same cycle
  assign base = init ? INIT_V : acc_reg;
  assign sum  = base + DST_V;
  assign sel  = (sum >= SRC_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= INIT_V;
    end else if (step) begin
      acc_reg <= sel ? (sum - SRC_V) : sum;
    end else if (init) begin
      acc_reg <= INIT_V;
    end
  end

endmodule

// File: rtl/ds_nn_scaler.sv
// Streaming nearest-neighbour downscaler (SRC_W x SRC_H -> DST_W x DST_H) with valid/ready on both sides.
// Build option DS_SCALER_CENTER_EN selects phase-centred picking; counts and flags are unaffected.
module ds_nn_scaler
  import ds_scaler_pkg::*;
#(
  parameter int SRC_W = 256,
  parameter int SRC_H = 256,
  parameter int DST_W = 96,
  parameter int DST_H = 96,
  parameter int CH    = 3,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [CH*DW-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CH*DW-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof,
  output logic             frame_done,
  output logic             sync_err
);

  localparam int XW = cnt_width(SRC_W);
  localparam int YW = cnt_width(SRC_H);
  localparam int CW = cnt_width(DST_W);
  localparam int RW = cnt_width(DST_H);
  localparam logic [XW-1:0] X_LAST = XW'(SRC_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SRC_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DST_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(DST_H - 1);

  state_t           state_reg;
  logic [XW-1:0]    x_reg;
  logic [YW-1:0]    y_reg;
  logic [CW-1:0]    col_reg;
  logic [RW-1:0]    row_reg;
  logic             ready_en_reg;
  logic             m_valid_reg;
  logic             m_sof_reg;
  logic             m_eol_reg;
  logic             m_eof_reg;
  logic [CH*DW-1:0] m_data_reg;
  logic             frame_done_reg;
  logic             sync_err_reg;

  logic          accept;
  logic          restart;
  logic          process;
  logic [XW-1:0] x_cur;
  logic [YW-1:0] y_cur;
  logic [CW-1:0] col_cur;
  logic [RW-1:0] row_cur;
  logic          line_end;
  logic          frame_end;
  logic          col_last;
  logic          row_last;
  logic          sel_x;
  logic          sel_y;
  logic          keep;

  assign s_ready = ready_en_reg & (~m_valid_reg | m_ready);
  assign accept  = s_valid & s_ready;
  assign restart = accept & s_sof;
  assign process = accept & (s_sof | (state_reg == ST_ACTIVE));

  // An s_sof pixel is always position (0,0) of a fresh frame, whatever the counters say.
  assign x_cur   = s_sof ? '0 : x_reg;
  assign y_cur   = s_sof ? '0 : y_reg;
  assign col_cur = s_sof ? '0 : col_reg;
  assign row_cur = s_sof ? '0 : row_reg;

  assign line_end  = (x_cur == X_LAST);
  assign frame_end = line_end & (y_cur == Y_LAST);
  assign col_last  = (col_cur == C_LAST);
  assign row_last  = (row_cur == R_LAST);
  assign keep      = process & sel_x & sel_y;

  ds_step_acc #(
    .SRC (SRC_W),
    .DST (DST_W)
  ) u_acc_x (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (process & (x_cur == '0)),
    .step  (process),
    .sel   (sel_x)
  );

  // Row decision is taken from the line's phase and held until the line ends.
  ds_step_acc #(
    .SRC (SRC_H),
    .DST (DST_H)
  ) u_acc_y (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (restart),
    .step  (process & line_end),
    .sel   (sel_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      ready_en_reg   <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_sof_reg      <= 1'b0;
      m_eol_reg      <= 1'b0;
      m_eof_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      ready_en_reg   <= 1'b1;
      frame_done_reg <= process & frame_end;
      if (restart && (state_reg == ST_ACTIVE)) begin
        sync_err_reg <= 1'b1;
      end

      if (process) begin
        if (frame_end) begin
          state_reg <= ST_IDLE;
          x_reg     <= '0;
          y_reg     <= '0;
        end else begin
          state_reg <= ST_ACTIVE;
          x_reg     <= line_end ? '0 : x_cur + 1'b1;
          y_reg     <= line_end ? y_cur + 1'b1 : y_cur;
        end
        if (keep) begin
          col_reg <= col_last ? '0 : col_cur + 1'b1;
          row_reg <= col_last ? (row_last ? '0 : row_cur + 1'b1) : row_cur;
        end else begin
          col_reg <= col_cur;
          row_reg <= row_cur;
        end
      end

      // accept implies the output slot is free, so a kept pixel can always overwrite it
      if (keep) begin
        m_valid_reg <= 1'b1;
        m_sof_reg   <= (col_cur == '0) && (row_cur == '0);
        m_eol_reg   <= col_last;
        m_eof_reg   <= col_last & row_last;
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_reg <= '0;
    end else if (keep) begin
      for (int k = 0; k < CH; k++) begin
        m_data_reg `DS_CH_SLICE(k, DW) <= s_data `DS_CH_SLICE(k, DW);
      end
    end
  end

  assign m_valid    = m_valid_reg;
  assign m_data     = m_data_reg;
  assign m_sof      = m_sof_reg;
  assign m_eol      = m_eol_reg;
  assign m_eof      = m_eof_reg;
  assign frame_done = frame_done_reg;
  assign sync_err   = sync_err_reg;

endmodule

// File: tb/tb_ds_nn_scaler.sv
// Bench for ds_nn_scaler: a 4x4->2x2 instance (id 0) for directed/random traffic and a
// 256x256->96x96 instance (id 1) for one continuous frame, both checked against a queue model.
module tb_ds_nn_scaler;

  localparam int PW = 24;
`ifdef DS_SCALER_CENTER_EN
  localparam bit CENTRED = 1'b1;
`else
  localparam bit CENTRED = 1'b0;
`endif

  typedef struct packed {
    logic [PW-1:0] d;
    logic          sof;
    logic          eol;
    logic          eof;
  } beat_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    s_valid = 2'b00;
  logic [1:0]    s_sof   = 2'b00;
  logic [1:0]    m_ready = 2'b11;
  logic [PW-1:0] s_data0 = '0;
  logic [PW-1:0] s_data1 = '0;
  wire  [1:0]    s_ready, m_valid, m_sof, m_eol, m_eof, frame_done, sync_err;
  wire  [PW-1:0] m_data0, m_data1;

  always #5 clk = ~clk;

  ds_nn_scaler #(.SRC_W(4), .SRC_H(4), .DST_W(2), .DST_H(2), .CH(3), .DW(8)) u_small (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_sof(s_sof[0]), .s_data(s_data0),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data0),
    .m_sof(m_sof[0]), .m_eol(m_eol[0]), .m_eof(m_eof[0]),
    .frame_done(frame_done[0]), .sync_err(sync_err[0])
  );

  ds_nn_scaler #(.SRC_W(256), .SRC_H(256), .DST_W(96), .DST_H(96), .CH(3), .DW(8)) u_big (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_sof(s_sof[1]), .s_data(s_data1),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data1),
    .m_sof(m_sof[1]), .m_eol(m_eol[1]), .m_eof(m_eof[1]),
    .frame_done(frame_done[1]), .sync_err(sync_err[1])
  );

  int tests = 0;
  int fails = 0;

  int            mx[2], my[2];
  bit            active[2], serr_exp[2], fd_exp[2], hold[2];
  beat_t         hold_val[2];
  beat_t         q0[$];
  beat_t         q1[$];
  bit            last_acc;
  int            beats[2], eols[2], eofs[2], fdones[2];
  logic [PW-1:0] first_data[2];
  bit            got_first[2];

  function automatic int sdim(input int id);
    return (id == 0) ? 4 : 256;
  endfunction

  function automatic int ddim(input int id);
    return (id == 0) ? 2 : 96;
  endfunction

  // Output sample j covers source positions i with floor((i*d+ph)/s) == j; the last such i is kept.
  function automatic int pos_of(input int i, input int s, input int d);
    int ph;
    ph = CENTRED ? s / 2 : 0;
    return (i * d + ph) / s;
  endfunction

  function automatic bit keep_at(input int i, input int s, input int d);
    return pos_of(i + 1, s, d) != pos_of(i, s, d);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input int id, input bit sof, input logic [PW-1:0] d);
    int    s, t, col, row;
    beat_t b;
    s = sdim(id);
    t = ddim(id);
    if (sof) begin
      if (active[id]) serr_exp[id] = 1'b1;
      mx[id] = 0;
      my[id] = 0;
      active[id] = 1'b1;
    end
    if (!active[id]) return;
    if (keep_at(mx[id], s, t) && keep_at(my[id], s, t)) begin
      col   = pos_of(mx[id], s, t);
      row   = pos_of(my[id], s, t);
      b.d   = d;
      b.sof = (col == 0) && (row == 0);
      b.eol = (col == t - 1);
      b.eof = (col == t - 1) && (row == t - 1);
      if (id == 0) q0.push_back(b);
      else q1.push_back(b);
    end
    if (mx[id] == s - 1) begin
      mx[id] = 0;
      if (my[id] == s - 1) begin
        my[id] = 0;
        active[id] = 1'b0;
        fd_exp[id] = 1'b1;
      end else begin
        my[id]++;
      end
    end else begin
      mx[id]++;
    end
  endtask

  task automatic reset_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; active[i] = 0; serr_exp[i] = 0; fd_exp[i] = 0; hold[i] = 0;
    end
  endtask

  task automatic clear_stats(input int id);
    beats[id] = 0; eols[id] = 0; eofs[id] = 0; fdones[id] = 0; got_first[id] = 0;
    first_data[id] = '0;
  endtask

  // One clock: drive at the falling edge, check outputs, feed the model if the pixel is taken.
  task automatic tick(input int id, input bit v, input bit sof, input logic [PW-1:0] d, input bit mr);
    logic          sr, mv, fd, se;
    logic [PW-1:0] md;
    beat_t         obs, exp_b;
    int            qn;
    @(negedge clk);
    s_valid[id] = v;
    s_sof[id]   = sof;
    m_ready[id] = mr;
    if (id == 0) s_data0 = d;
    else s_data1 = d;
    #1;
    sr  = s_ready[id];
    mv  = m_valid[id];
    fd  = frame_done[id];
    se  = sync_err[id];
    md  = (id == 0) ? m_data0 : m_data1;
    obs = {md, m_sof[id], m_eol[id], m_eof[id]};
    chk("frame_done", fd, fd_exp[id]);
    chk("sync_err", se, serr_exp[id]);
    chk("s_ready", sr, (!mv) | mr);
    if (fd) fdones[id]++;
    if (hold[id]) begin
      chk("hold_valid", mv, 1'b1);
      chk("hold_beat", obs, hold_val[id]);
    end
    hold[id] = 1'b0;
    if (mv && !mr) begin
      hold[id] = 1'b1;
      hold_val[id] = obs;
    end
    if (mv && mr) begin
      qn = (id == 0) ? q0.size() : q1.size();
      tests++;
      assert (qn > 0) else begin
        fails++;
        $error("FAIL extra_beat: observed data %0h with nothing expected", md);
      end
      if (qn > 0) begin
        if (id == 0) exp_b = q0.pop_front();
        else exp_b = q1.pop_front();
        chk("beat", obs, exp_b);
        beats[id]++;
        if (obs.eol) eols[id]++;
        if (obs.eof) eofs[id]++;
        if (!got_first[id]) begin
          got_first[id] = 1'b1;
          first_data[id] = md;
        end
      end
    end
    last_acc   = v && sr;
    fd_exp[id] = 1'b0;
    if (last_acc) model_accept(id, sof, d);
  endtask

  task automatic send(input int id, input bit sof, input logic [PW-1:0] d, input bit rnd);
    bit v, mr;
    last_acc = 1'b0;
    for (int n = 0; n < 64 && !last_acc; n++) begin
      v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      mr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(id, v, sof, d, mr);
    end
    tests++;
    assert (last_acc) else begin
      fails++;
      $error("FAIL send_timeout: pixel %0h not accepted, expected accept within 64 cycles", d);
    end
  endtask

  task automatic drain(input int id);
    repeat (6) tick(id, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    reset_model();
    clear_stats(0);
    clear_stats(1);

    // reset state
    #1;
    chk("rst_m_valid", m_valid, 2'b00);
    chk("rst_s_ready", s_ready, 2'b00);
    chk("rst_frame_done", frame_done, 2'b00);
    chk("rst_sync_err", sync_err, 2'b00);
    chk("rst_flags", {m_sof, m_eol, m_eof}, 6'b0);
    chk("rst_m_data", m_data0, 24'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s_ready_after_reset", s_ready, 2'b11);

    // directed 4x4 frame, data = pixel index
    for (int p = 0; p < 16; p++) send(0, p == 0, PW'(p), 1'b0);
    drain(0);
    chk("t1_beats", beats[0], 4);
    chk("t1_eols", eols[0], 2);
    chk("t1_eofs", eofs[0], 1);
    chk("t1_frame_done", fdones[0], 1);
    chk("t1_first", first_data[0], CENTRED ? 0 : 5);

    // downstream stall of 3 cycles while a pixel is held
    clear_stats(0);
    for (int p = 0; p < 6; p++) send(0, p == 0, PW'(p), 1'b0);
    repeat (3) tick(0, 1'b1, 1'b0, PW'(6), 1'b0);
    for (int p = 6; p < 16; p++) send(0, 1'b0, PW'(p), 1'b0);
    drain(0);
    chk("t2_beats", beats[0], 4);
    chk("t2_eofs", eofs[0], 1);
    chk("t2_q_empty", q0.size(), 0);

    // random data and handshakes, stray pixels between frames
    clear_stats(0);
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 3)) send(0, 1'b0, PW'($urandom), 1'b1);
      for (int p = 0; p < 16; p++) send(0, p == 0, PW'($urandom), 1'b1);
    end
    drain(0);
    chk("t3_beats", beats[0], 16);
    chk("t3_eofs", eofs[0], 4);
    chk("t3_frame_done", fdones[0], 4);
    chk("t3_q_empty", q0.size(), 0);

    // s_sof at source pixel 6 restarts the frame
    clear_stats(0);
    for (int p = 0; p < 6; p++) send(0, p == 0, PW'(100 + p), 1'b0);
    for (int k = 0; k < 16; k++) send(0, k == 0, PW'(k), 1'b0);
    drain(0);
    chk("t4_sync_err", sync_err[0], 1'b1);
    chk("t4_beats", beats[0], 5);
    chk("t4_eofs", eofs[0], 1);
    chk("t4_frame_done", fdones[0], 1);

    // reset mid-frame with an output pending
    for (int p = 0; p < 6; p++) send(0, p == 0, PW'(p), 1'b0);
    @(negedge clk);
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b0;
    #1;
    chk("t5_pending", m_valid[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_m_valid", m_valid[0], 1'b0);
    chk("t5_rst_sync_err", sync_err[0], 1'b0);
    reset_model();
    clear_stats(0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_s_ready", s_ready, 2'b11);
    for (int p = 0; p < 5; p++) send(0, 1'b0, PW'(200 + p), 1'b0);
    drain(0);
    chk("t5_dropped", beats[0], 0);
    for (int p = 0; p < 16; p++) send(0, p == 0, PW'(p), 1'b0);
    drain(0);
    chk("t5_beats", beats[0], 4);
    chk("t5_frame_done", fdones[0], 1);

    // full 256x256 -> 96x96 frame, continuous
    clear_stats(1);
    for (int p = 0; p < 65536; p++) send(1, p == 0, PW'(p), 1'b0);
    drain(1);
    chk("t6_beats", beats[1], 96 * 96);
    chk("t6_eols", eols[1], 96);
    chk("t6_eofs", eofs[1], 1);
    chk("t6_frame_done", fdones[1], 1);
    chk("t6_first", first_data[1], CENTRED ? 257 : 2 * 256 + 2);
    chk("t6_q_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
